// File: rtl/dec139_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the 74x139-half arbiter.
interface dec139_rr_arbiter_if;
  logic [3:0] REQ_L;
  logic       G_L;
  logic       A;
  logic       B;
  logic [3:0] GNT_L;
  logic       BUSY;

  // Requester side: drives requests, observes the grant.
  modport master (
    output REQ_L,
    input  G_L, A, B, GNT_L, BUSY
  );

  // Arbiter side: samples requests, drives decoder enable/select and grant.
  modport slave (
    input  REQ_L,
    output G_L, A, B, GNT_L, BUSY
  );
endinterface

// File: rtl/dec139_rr_arbiter.sv
// Four-requester round-robin arbiter driving one half of a 74x139 decoder.
// Grants are held for at most MAX_HOLD cycles while others wait, and every
// handoff passes through a one-cycle GAP with the decoder disabled.
module dec139_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic                 CLK,
  input logic                 RESET,
  dec139_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] own_q, own_d;
  logic [3:0] hc_q, hc_d;
  logic       g_l_q, g_l_d;
  logic       busy_q, busy_d;
  logic [3:0] gnt_l_q, gnt_l_d;

  logic [3:0] req;
  logic [1:0] win;
  logic       win_vld;
  logic [1:0] scan_idx;
  logic       others_req;

  assign req = ~bus.REQ_L;

  // Round-robin scan starting at ptr; first active request wins.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_vld && req[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  // Any requester other than the current owner is waiting.
  always_comb begin
    others_req = |(req & ~(4'b0001 << own_q));
  end

  // Next-state, pointer, hold counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    hc_d    = hc_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          own_d   = win;
          ptr_d   = win + 2'd1;
          hc_d    = '0;
        end
      end
      GRANT: begin
        // A release takes precedence; preemption yields the same GAP anyway.
        // ">=" rather than "==" so a saturated counter still allows preemption
        // when a second requester shows up late.
        if (!req[own_q]) begin
          state_d = GAP;
        end else if ((hc_q >= HOLD_LIM) && others_req) begin
          state_d = GAP;
        end else if (hc_q != HOLD_MAX) begin
          hc_d = hc_q + 4'd1;
        end
      end
      GAP: begin
        if (win_vld) begin
          state_d = GRANT;
          own_d   = win;
          ptr_d   = win + 2'd1;
          hc_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    g_l_d   = (state_d != GRANT);
    busy_d  = (state_d != IDLE);
    gnt_l_d = g_l_d ? 4'b1111 : ~(4'b0001 << own_d);
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      hc_q    <= '0;
      g_l_q   <= 1'b1;
      busy_q  <= 1'b0;
      gnt_l_q <= '1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      hc_q    <= hc_d;
      g_l_q   <= g_l_d;
      busy_q  <= busy_d;
      gnt_l_q <= gnt_l_d;
    end
  end

  assign bus.G_L   = g_l_q;
  assign bus.A     = own_q[0];
  assign bus.B     = own_q[1];
  assign bus.GNT_L = gnt_l_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_dec139_rr_arbiter.sv
// Directed bench for dec139_rr_arbiter with hand-computed expectations.
module tb_dec139_rr_arbiter;

  logic CLK;
  logic RESET;
  int   total;
  int   bad;

  dec139_rr_arbiter_if bus ();

  dec139_rr_arbiter #(.MAX_HOLD(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full output check: one-hot grant, enable, select code and busy.
  task automatic chk_out(input string tag, input logic [3:0] gnt, input logic g_l,
                         input logic [1:0] ba, input logic busy);
    chk({tag, ".gnt"},  bus.GNT_L, gnt);
    chk({tag, ".g_l"},  {3'b000, bus.G_L}, {3'b000, g_l});
    chk({tag, ".ba"},   {2'b00, bus.B, bus.A}, {2'b00, ba});
    chk({tag, ".busy"}, {3'b000, bus.BUSY}, {3'b000, busy});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [3:0] exp_gnt;
    int         rr_idx[5];
    total = 0;
    bad   = 0;
    rr_idx = '{0, 1, 2, 3, 0};

    // Reset with all requests active.
    RESET     = 1'b1;
    bus.REQ_L = 4'b0000;
    #3;
    chk_out("rst0", 4'b1111, 1'b1, 2'b00, 1'b0);
    tick();
    tick();
    chk_out("rst1", 4'b1111, 1'b1, 2'b00, 1'b0);
    RESET = 1'b0;
    tick();
    chk_out("rst_first", 4'b1110, 1'b0, 2'b00, 1'b1);
    bus.REQ_L = 4'b1111;
    tick();
    chk_out("rst_gap", 4'b1111, 1'b1, 2'b00, 1'b1);
    tick();
    chk_out("rst_idle", 4'b1111, 1'b1, 2'b00, 1'b0);

    // Sole requester 2 is never preempted (ptr=1 here).
    bus.REQ_L = 4'b1011;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_out("single", 4'b1011, 1'b0, 2'b10, 1'b1);
    end
    bus.REQ_L = 4'b1111;
    tick();
    chk_out("single_gap", 4'b1111, 1'b1, 2'b10, 1'b1);
    tick();
    chk_out("single_idle", 4'b1111, 1'b1, 2'b10, 1'b0);

    // ptr=3 after granting 2: index 3 is scanned first, then 0 via wrap.
    bus.REQ_L = 4'b0110;
    tick();
    chk_out("wrap_g3", 4'b0111, 1'b0, 2'b11, 1'b1);
    bus.REQ_L = 4'b1110;
    tick();
    chk_out("wrap_gap", 4'b1111, 1'b1, 2'b11, 1'b1);
    tick();
    chk_out("wrap_g0", 4'b1110, 1'b0, 2'b00, 1'b1);
    bus.REQ_L = 4'b1111;
    tick();
    chk_out("wrap_gap2", 4'b1111, 1'b1, 2'b00, 1'b1);
    tick();
    chk_out("wrap_idle", 4'b1111, 1'b1, 2'b00, 1'b0);

    // Release handoff: 1 owns for 3 cycles while 3 waits (ptr=1).
    bus.REQ_L = 4'b1101;
    tick();
    chk_out("hand_g1a", 4'b1101, 1'b0, 2'b01, 1'b1);
    bus.REQ_L = 4'b0101;
    tick();
    chk_out("hand_g1b", 4'b1101, 1'b0, 2'b01, 1'b1);
    tick();
    chk_out("hand_g1c", 4'b1101, 1'b0, 2'b01, 1'b1);
    bus.REQ_L = 4'b0111;
    tick();
    chk_out("hand_gap", 4'b1111, 1'b1, 2'b01, 1'b1);
    tick();
    chk_out("hand_g3", 4'b0111, 1'b0, 2'b11, 1'b1);
    bus.REQ_L = 4'b1111;
    tick();
    chk_out("hand_gap2", 4'b1111, 1'b1, 2'b11, 1'b1);
    tick();
    chk_out("hand_idle", 4'b1111, 1'b1, 2'b11, 1'b0);

    // Round robin under full load (ptr=0): 0,1,2,3,0 for 8 cycles each.
    bus.REQ_L = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b1111;
      exp_gnt[rr_idx[k]] = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick();
        chk_out("rr_grant", exp_gnt, 1'b0, 2'(rr_idx[k]), 1'b1);
      end
      tick();
      chk_out("rr_gap", 4'b1111, 1'b1, 2'(rr_idx[k]), 1'b1);
    end
    tick();
    chk_out("rr_g1", 4'b1101, 1'b0, 2'b01, 1'b1);

    // Asynchronous reset between edges drops the grant at once.
    #2;
    RESET = 1'b1;
    #1;
    chk_out("arst", 4'b1111, 1'b1, 2'b00, 1'b0);
    chk("arst_known", {3'b000, $isunknown({bus.A, bus.B})}, 4'b0000);
    tick();
    chk_out("arst_hold", 4'b1111, 1'b1, 2'b00, 1'b0);
    RESET = 1'b0;
    tick();
    chk_out("arst_first", 4'b1110, 1'b0, 2'b00, 1'b1);
    bus.REQ_L = 4'b1111;
    tick();
    chk_out("end_gap", 4'b1111, 1'b1, 2'b00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
